// File: rtl/ad2s1210_emu_pkg.sv
// ad2s1210_emu_pkg: shared types, constants and helpers
// for the AD2S1210 resolver-to-digital emulator.
package ad2s1210_emu_pkg;

    // Minimum clock:SCLK ratio the synchronisers are sized for.
    localparam int CLOCK_DIV_MIN = 8;

    typedef enum logic [1:0] {
        MODE_POS  = 2'b00,
        MODE_VEL  = 2'b01,
        MODE_RSVD = 2'b10,
        MODE_CFG  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        RES_10 = 2'b00,
        RES_12 = 2'b01,
        RES_14 = 2'b10,
        RES_16 = 2'b11
    } res_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_e;

    localparam logic [4:0] NORM_BITS = 5'd24;
    localparam logic [4:0] CFG_BITS  = 5'd8;

    localparam logic [3:0] TDEST_ANGLE = 4'd0;
    localparam logic [3:0] TDEST_SPEED = 4'd1;

    localparam logic [7:0] ADDR_THR_LO = 8'h88;
    localparam logic [7:0] ADDR_THR_HI = 8'h8E;
    localparam logic [7:0] ADDR_EXC    = 8'h91;
    localparam logic [7:0] ADDR_CTRL   = 8'h92;
    localparam logic [7:0] ADDR_FAULT  = 8'hFF;

    localparam logic [7:0] PTR_DEFAULT  = 8'h00;
    localparam logic [7:0] THR_DEFAULT  = 8'h00;
    localparam logic [7:0] EXC_DEFAULT  = 8'h28;
    localparam logic [7:0] CTRL_DEFAULT = 8'h7E;

    // Left-aligned data: bits below the resolution read 0.
    function automatic logic [15:0] res_mask(input res_e r);
        logic [15:0] m;
        unique case (r)
            RES_10: m = 16'hFFC0;
            RES_12: m = 16'hFFF0;
            RES_14: m = 16'hFFFC;
            RES_16: m = 16'hFFFF;
        endcase
        return m;
    endfunction

    // Bit that makes the total count of ones odd.
    function automatic logic odd_parity(input logic [22:0] v);
        return ~(^v);
    endfunction

endpackage

// File: rtl/axi_stream.sv
// axi_stream: minimal 16-bit AXI-stream bundle
// carrying position/speed beats into the emulator.
interface axi_stream;
    logic        tvalid;
    logic        tready;
    logic [15:0] tdata;
    logic [3:0]  tdest;

    modport master (output tvalid, tdata, tdest, input tready);
    modport slave  (input tvalid, tdata, tdest, output tready);
endinterface

// File: rtl/ad2s1210_emu_sync_edge.sv
// ad2s1210_emu_sync_edge: 2-flop synchroniser plus a
// delay flop that yields single-cycle rise/fall pulses.
module ad2s1210_emu_sync_edge #(
    parameter int           W       = 1,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q,
    output logic [W-1:0] rise,
    output logic [W-1:0] fall
);

    logic [W-1:0] meta_q, meta_d;
    logic [W-1:0] sync_q, sync_d;
    logic [W-1:0] dly_q,  dly_d;

    // Shift the pin through the synchroniser chain.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
        dly_d  = sync_q;
    end

    // Chain registers; reset to the pin's idle level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            dly_q  <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            dly_q  <= dly_d;
        end
    end

    assign q    = sync_q;
    assign rise = sync_q & ~dly_q;
    assign fall = ~sync_q & dly_q;

endmodule

// File: rtl/ad2s1210_emulator.sv
// ad2s1210_emulator: pin-level AD2S1210 model fed by AXI-stream.
// Optional register mode: AD2S1210_EMU_CONFIG_MODE_EN.
module ad2s1210_emulator
    import ad2s1210_emu_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       SS,
    input  logic       SCLK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [1:0] R_A,
    input  logic [1:0] R_RES,
    input  logic       R_SAMPLE,
    input  logic [7:0] fault_in,
    axi_stream.slave   data_in
);

    logic ss_s, ss_rise, ss_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic smp_s, smp_rise, smp_fall;
    logic [1:0] ra_s, ra_rise, ra_fall;
    logic [1:0] res_s, res_rise, res_fall;

    ad2s1210_emu_sync_edge #(.W(1), .RST_VAL(1'b1)) u_ss (
        .clk(clock), .rst_n(reset), .d(SS),
        .q(ss_s), .rise(ss_rise), .fall(ss_fall));
    ad2s1210_emu_sync_edge #(.W(1), .RST_VAL(1'b1)) u_sclk (
        .clk(clock), .rst_n(reset), .d(SCLK),
        .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
    ad2s1210_emu_sync_edge #(.W(1), .RST_VAL(1'b0)) u_mosi (
        .clk(clock), .rst_n(reset), .d(MOSI),
        .q(mosi_s), .rise(mosi_rise), .fall(mosi_fall));
    ad2s1210_emu_sync_edge #(.W(1), .RST_VAL(1'b1)) u_smp (
        .clk(clock), .rst_n(reset), .d(R_SAMPLE),
        .q(smp_s), .rise(smp_rise), .fall(smp_fall));
    ad2s1210_emu_sync_edge #(.W(2), .RST_VAL(2'b00)) u_ra (
        .clk(clock), .rst_n(reset), .d(R_A),
        .q(ra_s), .rise(ra_rise), .fall(ra_fall));
    ad2s1210_emu_sync_edge #(.W(2), .RST_VAL(2'b00)) u_res (
        .clk(clock), .rst_n(reset), .d(R_RES),
        .q(res_s), .rise(res_rise), .fall(res_fall));

    mode_e mode_s;
    res_e  res_sel;
    assign mode_s  = mode_e'(ra_s);
    assign res_sel = res_e'(res_s);

    state_e      state_q, state_d;
    logic        miso_q, miso_d;
    logic [23:0] shreg_q, shreg_d;
    logic [4:0]  cnt_q, cnt_d, cnt_nx, frame_len;
    logic        cfg_q, cfg_d;
    logic [7:0]  mosi_sr_q, mosi_sr_d;
    logic [15:0] angle_live_q, angle_live_d;
    logic [15:0] speed_live_q, speed_live_d;
    logic [15:0] angle_hold_q, angle_hold_d;
    logic [15:0] speed_hold_q, speed_hold_d;
    logic [7:0]  fault_hold_q, fault_hold_d;
    logic        frame_done, fault_clr;
    logic        cfg_fault_rd;
    logic [7:0]  cfg_rd;
    logic [15:0] data_sel, data_m;
    logic [7:0]  fault_tx;
    logic [23:0] norm_word;
    logic        is_cfg;

    assign data_in.tready = 1'b1;
    assign MISO           = miso_q;
    assign is_cfg         = (mode_s == MODE_CFG);

    // Build the normal-mode word from held data and faults.
    always_comb begin
        data_sel  = (mode_s == MODE_VEL) ? speed_hold_q : angle_hold_q;
        data_m    = data_sel & res_mask(res_sel);
        fault_tx  = {fault_hold_q[7:1],
                     odd_parity({data_m, fault_hold_q[7:1]})};
        norm_word = {data_m, fault_tx};
    end

    // Frame FSM: load on SS fall, shift on SCLK rise.
    always_comb begin
        state_d    = state_q;
        miso_d     = miso_q;
        shreg_d    = shreg_q;
        cnt_d      = cnt_q;
        cfg_d      = cfg_q;
        mosi_sr_d  = mosi_sr_q;
        frame_done = 1'b0;
        cnt_nx     = cnt_q + 5'd1;
        frame_len  = cfg_q ? CFG_BITS : NORM_BITS;
        if (sclk_fall) begin
            mosi_sr_d = {mosi_sr_q[6:0], mosi_s};
        end
        unique case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (ss_fall) begin
                    state_d = ST_LOAD;
                    cnt_d   = '0;
                    cfg_d   = is_cfg;
                    shreg_d = is_cfg ? {cfg_rd, 16'h0000} : norm_word;
                    miso_d  = shreg_d[23];
                end
            end
            ST_LOAD: begin
                state_d = ST_SHIFT;
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end
            end
            ST_SHIFT: begin
                if (ss_rise) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else if (sclk_rise) begin
                    shreg_d = {shreg_q[22:0], 1'b0};
                    miso_d  = shreg_q[22];
                    cnt_d   = cnt_nx;
                    if (cnt_nx == frame_len) begin
                        state_d    = ST_DONE;
                        miso_d     = 1'b0;
                        frame_done = 1'b1;
                    end
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
                if (ss_rise) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    assign fault_clr = frame_done & (~cfg_q | cfg_fault_rd);

    // Live capture, sample latch and sticky fault.
    always_comb begin
        angle_live_d = angle_live_q;
        speed_live_d = speed_live_q;
        angle_hold_d = angle_hold_q;
        speed_hold_d = speed_hold_q;
        fault_hold_d = fault_hold_q;
        if (fault_clr) begin
            fault_hold_d = '0;
        end
        if (smp_fall) begin
            angle_hold_d = angle_live_q;
            speed_hold_d = speed_live_q;
            fault_hold_d = fault_hold_d | {fault_in[7:1], 1'b0};
        end
        if (data_in.tvalid) begin
            unique case (1'b1)
                (data_in.tdest == TDEST_ANGLE):
                    angle_live_d = data_in.tdata;
                (data_in.tdest == TDEST_SPEED):
                    speed_live_d = data_in.tdata;
                default: ;
            endcase
        end
    end

    // Frame and data registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            miso_q       <= 1'b0;
            shreg_q      <= '0;
            cnt_q        <= '0;
            cfg_q        <= 1'b0;
            mosi_sr_q    <= '0;
            angle_live_q <= '0;
            speed_live_q <= '0;
            angle_hold_q <= '0;
            speed_hold_q <= '0;
            fault_hold_q <= '0;
        end else begin
            state_q      <= state_d;
            miso_q       <= miso_d;
            shreg_q      <= shreg_d;
            cnt_q        <= cnt_d;
            cfg_q        <= cfg_d;
            mosi_sr_q    <= mosi_sr_d;
            angle_live_q <= angle_live_d;
            speed_live_q <= speed_live_d;
            angle_hold_q <= angle_hold_d;
            speed_hold_q <= speed_hold_d;
            fault_hold_q <= fault_hold_d;
        end
    end

`ifdef AD2S1210_EMU_CONFIG_MODE_EN
    logic [7:0] ptr_q, ptr_d;
    logic [7:0] exc_q, exc_d;
    logic [7:0] ctrl_q, ctrl_d;
    logic [7:0] thr_q [8];
    logic [7:0] thr_d [8];
    logic       in_thr;

    assign in_thr = (ptr_q >= ADDR_THR_LO) && (ptr_q <= ADDR_THR_HI);
    assign cfg_fault_rd = (ptr_q == ADDR_FAULT);

    // Register read mux at the current pointer.
    always_comb begin
        cfg_rd = 8'h00;
        unique case (1'b1)
            in_thr:                 cfg_rd = thr_q[ptr_q[2:0]];
            (ptr_q == ADDR_EXC):    cfg_rd = exc_q;
            (ptr_q == ADDR_CTRL):   cfg_rd = ctrl_q;
            (ptr_q == ADDR_FAULT):  cfg_rd = fault_hold_q;
            default: ;
        endcase
    end

    // Address frames move the pointer, data frames write it.
    always_comb begin
        ptr_d  = ptr_q;
        exc_d  = exc_q;
        ctrl_d = ctrl_q;
        thr_d  = thr_q;
        if (frame_done && cfg_q) begin
            if (mosi_sr_q[7]) begin
                ptr_d = mosi_sr_q;
            end else begin
                unique case (1'b1)
                    in_thr:
                        thr_d[ptr_q[2:0]] = {1'b0, mosi_sr_q[6:0]};
                    (ptr_q == ADDR_EXC):
                        exc_d = {1'b0, mosi_sr_q[6:0]};
                    (ptr_q == ADDR_CTRL):
                        ctrl_d = {1'b0, mosi_sr_q[6:0]};
                    default: ;
                endcase
            end
        end
    end

    // Configuration registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q  <= PTR_DEFAULT;
            exc_q  <= EXC_DEFAULT;
            ctrl_q <= CTRL_DEFAULT;
            for (int i = 0; i < 8; i++) begin
                thr_q[i] <= THR_DEFAULT;
            end
        end else begin
            ptr_q  <= ptr_d;
            exc_q  <= exc_d;
            ctrl_q <= ctrl_d;
            thr_q  <= thr_d;
        end
    end

    logic unused_cfg;
    assign unused_cfg = 1'b0;
`else
    assign cfg_rd       = 8'h00;
    assign cfg_fault_rd = 1'b0;

    logic unused_cfg;
    assign unused_cfg = ^mosi_sr_q;
`endif

    logic unused_sig;
    assign unused_sig = ^{ss_s, sclk_s, mosi_s, mosi_rise, mosi_fall,
                          smp_s, smp_rise, ra_rise, ra_fall,
                          res_rise, res_fall, fault_in[0], unused_cfg};

endmodule
